// File: rtl/sensor_log_writer_pkg.sv
// Shared definitions for the sensor log writer: FSM state encoding, the
// pointer width and the default memory bank select used for log writes.
package sensor_log_writer_pkg;

    localparam int PTR_W = 6;
    localparam logic [2:0] LOG_SEL_DEFAULT = 3'b010;

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        IDLE  = 3'd1,
        PRECH = 3'd2,
        SETUP = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Channel index width; a single-channel build still needs one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sensor_log_writer_ptr_bank.sv
// Per-channel ring write pointers with sticky wrap flags. Clear beats load,
// load beats increment.
module log_ptr_bank
    import sensor_log_writer_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DEPTH  = 16,
    parameter int CH_W   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      load_en,
    input  logic [NUM_CH*PTR_W-1:0]   load_vec,
    input  logic                      inc_en,
    input  logic [CH_W-1:0]           ch,
    output logic [NUM_CH*PTR_W-1:0]   ptr_vec,
    output logic [PTR_W-1:0]          ch_ptr,
    output logic [NUM_CH-1:0]         overflow
);

    localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_q [NUM_CH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) ptr_q[c] <= '0;
            overflow <= '0;
        end else if (clear) begin
            for (int c = 0; c < NUM_CH; c++) ptr_q[c] <= '0;
            overflow <= '0;
        end else if (load_en) begin
            for (int c = 0; c < NUM_CH; c++)
                ptr_q[c] <= load_vec[c*PTR_W +: PTR_W] & PTR_MASK;
        end else if (inc_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (CH_W'(c) == ch) begin
                    ptr_q[c] <= (ptr_q[c] + PTR_W'(1)) & PTR_MASK;
                    if (ptr_q[c] == PTR_MASK) overflow[c] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_vec = '0;
        ch_ptr  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ptr_vec[c*PTR_W +: PTR_W] = ptr_q[c];
            if (CH_W'(c) == ch) ch_ptr = ptr_q[c];
        end
    end

endmodule

// File: rtl/sensor_log_writer.sv
// Logs timestamped ADC samples into per-channel memory rings using a
// precharge / setup / write handshake on a write-only memory port.
module sensor_log_writer
    import sensor_log_writer_pkg::*;
#(
    parameter int         NUM_CH    = 3,
    parameter int         DEPTH     = 16,
    parameter logic [5:0] BASE_ADDR = 6'd16,
    parameter logic [2:0] LOG_SEL   = LOG_SEL_DEFAULT,
    parameter int         WE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    factory_reset,
    input  logic                    ADC_data_ready,
    input  logic [7:0]              ADC_data,
    input  logic [NUM_CH-1:0]       sensor_code,
    input  logic [7:0]              sensor_time_stamp,
    input  logic [NUM_CH*PTR_W-1:0] Counter_in,
    output logic [NUM_CH*PTR_W-1:0] Counter_out,
    output logic [15:0]             mem_data_out,
    output logic                    PC_B,
    output logic                    WE,
    output logic                    SE,
    output logic [PTR_W-1:0]        mem_address,
    output logic [2:0]              mem_sel,
    output logic                    busy,
    output logic                    log_done,
    output logic [NUM_CH-1:0]       overflow,
    output logic                    dropped
);

    localparam int CH_W  = ch_width(NUM_CH);
    localparam int CNT_W = $clog2(WE_CYCLES + 1);

    state_t            state_q, state_d;
    logic              capture;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [15:0]       word_q;
    logic [CNT_W-1:0]  we_cnt_q;
    logic              dropped_q;
    logic              in_flight;
    logic [PTR_W-1:0]  ch_ptr;
    logic [PTR_W-1:0]  addr_calc;

    assign in_flight = (state_q == PRECH) || (state_q == SETUP) ||
                       (state_q == WRITE) || (state_q == DONE);

    // Lowest set bit of the channel select wins when several are set.
    always_comb begin
        ch_d = '0;
        for (int c = NUM_CH - 1; c >= 0; c--)
            if (sensor_code[c]) ch_d = CH_W'(c);
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            LOAD:  state_d = IDLE;
            IDLE: begin
                if (ADC_data_ready && (|sensor_code)) begin
                    state_d = PRECH;
                    capture = 1'b1;
                end
            end
            PRECH: state_d = SETUP;
            SETUP: state_d = WRITE;
            WRITE: if (we_cnt_q == CNT_W'(WE_CYCLES - 1)) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (factory_reset) begin
            state_d = IDLE;
            capture = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= LOAD;
            ch_q      <= '0;
            word_q    <= '0;
            we_cnt_q  <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                ch_q   <= ch_d;
                word_q <= {sensor_time_stamp, ADC_data};
            end
            if (state_q == SETUP)
                we_cnt_q <= '0;
            else if (state_q == WRITE)
                we_cnt_q <= we_cnt_q + CNT_W'(1);
            if (factory_reset)
                dropped_q <= 1'b0;
            else if (ADC_data_ready && (in_flight || state_q == LOAD))
                dropped_q <= 1'b1;
        end
    end

    log_ptr_bank #(
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH),
        .CH_W   (CH_W)
    ) u_ptr_bank (
        .clk      (clk),
        .reset    (reset),
        .clear    (factory_reset),
        .load_en  (state_q == LOAD),
        .load_vec (Counter_in),
        .inc_en   (state_q == DONE),
        .ch       (ch_q),
        .ptr_vec  (Counter_out),
        .ch_ptr   (ch_ptr),
        .overflow (overflow)
    );

    // Address arithmetic is done wide and then truncated to the word-line width.
    assign addr_calc = PTR_W'(int'(BASE_ADDR) + int'(ch_q) * DEPTH + int'(ch_ptr));

    always_comb begin
        PC_B         = 1'b1;
        WE           = 1'b0;
        busy         = 1'b0;
        log_done     = 1'b0;
        mem_address  = '0;
        mem_data_out = '0;
        mem_sel      = 3'b000;
        unique case (state_q)
            PRECH: begin
                busy    = 1'b1;
                PC_B    = 1'b0;
                mem_sel = LOG_SEL;
            end
            SETUP: begin
                busy         = 1'b1;
                mem_sel      = LOG_SEL;
                mem_address  = addr_calc;
                mem_data_out = word_q;
            end
            WRITE: begin
                busy         = 1'b1;
                WE           = 1'b1;
                mem_sel      = LOG_SEL;
                mem_address  = addr_calc;
                mem_data_out = word_q;
            end
            DONE: begin
                busy     = 1'b1;
                log_done = 1'b1;
                mem_sel  = LOG_SEL;
            end
            default: ;
        endcase
    end

    assign SE      = 1'b0;
    assign dropped = dropped_q;

endmodule

// File: doc/sensor_log_writer.md
SENSOR_LOG_WRITER -- requirements
Module: sensor_log_writer

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of sensor channels (1..8).
REQ-002 SHALL have parameter DEPTH, default 16: words per channel ring (power of 2, NUM_CH*DEPTH <= 64).
REQ-003 SHALL have parameter BASE_ADDR, default 6'd16: mem_address of channel 0, word 0.
REQ-004 SHALL have parameter LOG_SEL, default 3'b010: mem_sel value driven during log writes.
REQ-005 SHALL have parameter WE_CYCLES, default 2: cycles WE is held high per write.
REQ-006 SHALL have ports (name  direction  width  meaning), one per line:
 clk  in  1  single clock; reset is asynchronous and active-high.
 reset  in  1  asynchronous, active-high reset.
 factory_reset  in  1  synchronous clear of all log state.
 ADC_data_ready  in  1  one-cycle pulse: new sample valid.
 ADC_data  in  8  sample value.
 sensor_code  in  NUM_CH  channel select, expected one-hot.
 sensor_time_stamp  in  8  timestamp paired with the sample.
 Counter_in  in  NUM_CH*6  persisted per-channel write pointers from the always-on domain.
 Counter_out  out  NUM_CH*6  live per-channel write pointers to the always-on domain.
 mem_data_out  out  16  write word to memory.
 PC_B, WE, SE  out  1 each  memory precharge (active-low), write enable, sense enable.
 mem_address  out  6  word line.
 mem_sel  out  3  memory bank select.
 busy  out  1  write in progress.
 log_done  out  1  one-cycle pulse on write completion.
 overflow  out  NUM_CH  sticky: channel ring wrapped.
 dropped  out  1  sticky: sample arrived while busy.

Function
REQ-007 SHALL use FSM states LOAD, IDLE, PRECH, SETUP, WRITE, DONE.
REQ-008 After reset, SHALL sit in LOAD for one cycle, copy Counter_in[6c+:6] mod DEPTH into ptr[c], then go to IDLE.
REQ-009 In IDLE, on ADC_data_ready with sensor_code != 0, SHALL latch channel = lowest set bit, word = {sensor_time_stamp, ADC_data}, and go to PRECH next cycle.
REQ-010 ADC_data_ready with sensor_code == 0 SHALL be ignored, with no state change.
REQ-011 PRECH: PC_B=0 for 1 cycle. SETUP: PC_B=1, mem_address and mem_data_out valid, WE=0, 1 cycle. WRITE: WE=1 for exactly WE_CYCLES cycles, address and data held stable.
REQ-012 mem_address SHALL equal BASE_ADDR + ch*DEPTH + ptr[ch], truncated to 6 bits.
REQ-013 DONE (1 cycle): log_done=1; ptr[ch] <= (ptr[ch]+1) mod DEPTH; if ptr[ch] was DEPTH-1, overflow[ch] <= 1; then IDLE.
REQ-014 Latency from ADC_data_ready to log_done SHALL be 3+WE_CYCLES cycles (5 at default).
REQ-015 busy SHALL be 1 in PRECH, SETUP, WRITE and DONE, and 0 otherwise.
REQ-016 ADC_data_ready while busy=1 or in LOAD SHALL be dropped and set dropped=1; the in-flight write SHALL be unaffected.
REQ-017 Counter_out[6c+:6] SHALL equal zero-extended ptr[c] at all times after LOAD.
REQ-018 SE SHALL be 0 always (write-only block). mem_sel SHALL be LOG_SEL while busy and 3'b000 otherwise.
REQ-019 Idle outputs: PC_B=1, WE=0, mem_address=0, mem_data_out=0.
REQ-020 factory_reset SHALL take priority over all else: abort any write (WE=0 the next cycle), clear ptr, overflow and dropped, and go to IDLE without a LOAD.

Reset
REQ-021 reset SHALL asynchronously force state=LOAD, ptr=0, overflow=0, dropped=0, log_done=0, busy=0, PC_B=1, WE=0, SE=0, mem_address=0, mem_data_out=0, mem_sel=0, Counter_out=0.
REQ-022 reset asserted mid-write SHALL drop WE immediately; the pointer SHALL NOT advance.

Structure
REQ-023 The state encoding, the 6-bit pointer width and the LOG_SEL default SHALL live in the shared tag package.
REQ-024 SHALL instantiate one sub-module, log_ptr_bank: a per-channel pointer/overflow array with load, increment and clear operations.

Verification
REQ-025 Default params, Counter_in=0. Pulse ADC_data_ready, sensor_code=3'b010, ADC_data=8'hA5, ts=8'h3C -> write 16'h3CA5 at address 32, log_done at +5 cycles, Counter_out[11:6]=1.
REQ-026 16 writes to ch0 -> 17th write targets address 16, overflow=3'b001, Counter_out[5:0]=0.
REQ-027 Second ADC_data_ready 2 cycles after the first -> dropped=1, exactly one WE burst.
REQ-028 sensor_code=3'b110 -> ch1 written. sensor_code=0 -> no WE, busy stays 0.
REQ-029 Counter_in ch2=6'd7 at reset release -> first ch2 write to address 16+32+7=55.
REQ-030 factory_reset during WRITE -> WE=0 next cycle, all pointers 0, overflow=0, no log_done.
